// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin time-sharing controller for one external 8-bit ALU
module alu_share_ctrl #(
    parameter int DW   = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [DW-1:0]   req0_a,
    input  logic [DW-1:0]   req0_b,
    input  logic [2:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [DW-1:0]   req1_a,
    input  logic [DW-1:0]   req1_b,
    input  logic [2:0]      req1_op,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [2:0]      alu_op,
    input  logic [DW-1:0]   alu_o,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic            rsp_src,
    output logic            busy,
    output logic [CNTW-1:0] done_cnt0,
    output logic [CNTW-1:0] done_cnt1
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic            last_gnt_q;
    logic            src_q;
    logic [DW-1:0]   alu_a_q;
    logic [DW-1:0]   alu_b_q;
    logic [2:0]      alu_op_q;
    logic [DW-1:0]   rsp_data_q;
    logic            rsp_src_q;
    logic            rsp_valid_q;
    logic [CNTW-1:0] done_cnt0_q;
    logic [CNTW-1:0] done_cnt1_q;

    logic gnt0;
    logic gnt1;
    logic idle;

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        gnt0 = req0_valid & (~req1_valid | last_gnt_q);
        gnt1 = req1_valid & (~req0_valid | ~last_gnt_q);
        idle = (state_q == S_IDLE);
    end

    // Gated by rst_n so nothing is offered while reset is held.
    assign req0_ready = rst_n & idle & gnt0;
    assign req1_ready = rst_n & idle & gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_gnt_q  <= 1'b1;
            src_q       <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_data_q  <= '0;
            rsp_src_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            done_cnt0_q <= '0;
            done_cnt1_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt0 | gnt1) begin
                        alu_a_q    <= gnt1 ? req1_a  : req0_a;
                        alu_b_q    <= gnt1 ? req1_b  : req0_b;
                        alu_op_q   <= gnt1 ? req1_op : req0_op;
                        src_q      <= gnt1;
                        last_gnt_q <= gnt1;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data_q  <= alu_o;
                    rsp_src_q   <= src_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_src_q) begin
                            done_cnt1_q <= done_cnt1_q + 1'b1;
                        end else begin
                            done_cnt0_q <= done_cnt0_q + 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_src   = rsp_src_q;
    assign busy      = ~idle;
    assign done_cnt0 = done_cnt0_q;
    assign done_cnt1 = done_cnt1_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - vectors, corner sequences and random model check for alu_share_ctrl
module tb_alu_share_ctrl;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]    req0_op, req1_op;
    logic [DW-1:0] alu_a, alu_b, alu_o;
    logic [2:0]    alu_op;
    logic          rsp_valid, rsp_ready, rsp_src, busy;
    logic [DW-1:0] rsp_data;
    logic [CW-1:0] done_cnt0, done_cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.DW(DW), .CNTW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_o(alu_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_src(rsp_src), .busy(busy),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    // The shared ALU: ADD SUB SLL LSR AND OR XOR EQL
    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a << b[2:0];
            3'd3: return a >> b[2:0];
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: return {7'd0, a == b};
        endcase
    endfunction

    assign alu_o = alu_f(alu_op, alu_a, alu_b);

    typedef struct {
        logic       v0, v1;
        logic [2:0] op0;
        logic [7:0] a0, b0;
        logic [2:0] op1;
        logic [7:0] a1, b1;
        logic       exp_src;
        logic [7:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        rsp_ready = 1'b1;
        for (int i = 0; i < 30 && busy; i++) tick();
        chk("wait_idle", busy, 1'b0);
        rsp_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        wait_idle();
        req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
        #1;
        chk({name, "_ready0"}, req0_ready, v.exp_src == 1'b0);
        chk({name, "_ready1"}, req1_ready, v.exp_src == 1'b1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk({name, "_alu_a"}, alu_a, v.exp_src ? v.a1 : v.a0);
        chk({name, "_alu_b"}, alu_b, v.exp_src ? v.b1 : v.b0);
        chk({name, "_alu_op"}, alu_op, v.exp_src ? v.op1 : v.op0);
        chk({name, "_early_valid"}, rsp_valid, 1'b0);
        tick();
        chk({name, "_rsp_valid"}, rsp_valid, 1'b1);
        chk({name, "_rsp_data"}, rsp_data, v.exp_data);
        chk({name, "_rsp_src"}, rsp_src, v.exp_src);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({name, "_idle_after"}, busy, 1'b0);
    endtask

    vec_t vt[8];
    vec_t lone[4];

    int          got;
    logic [7:0]  c_data[3];
    logic        c_src[3];
    int          c_cyc[3];
    logic [CW-1:0] c0, c1;

    bit   m_busy;
    int   m_age;
    logic m_src, m_last;
    logic [7:0] m_res;
    int   m_cnt[2];
    bit   e_r0, e_r1, vis;

    initial begin
        // row: v0 v1 op0 a0 b0 op1 a1 b1 exp_src exp_data (grant history starts with last=1)
        vt[0] = '{1, 0, 3'd0, 8'd200, 8'd100, 3'd0, 8'd0,  8'd0,  0, 8'd44};
        vt[1] = '{1, 1, 3'd1, 8'd5,   8'd7,   3'd7, 8'h3C, 8'h3C, 1, 8'h01};
        vt[2] = '{1, 1, 3'd1, 8'd5,   8'd7,   3'd7, 8'h3C, 8'h3C, 0, 8'hFE};
        vt[3] = '{0, 1, 3'd0, 8'd0,   8'd0,   3'd6, 8'hAA, 8'hFF, 1, 8'h55};
        vt[4] = '{0, 1, 3'd0, 8'd0,   8'd0,   3'd0, 8'hFF, 8'h01, 1, 8'h00};
        vt[5] = '{1, 1, 3'd7, 8'h12,  8'h13,  3'd5, 8'hF0, 8'h0F, 0, 8'h00};
        vt[6] = '{1, 0, 3'd2, 8'h01,  8'd7,   3'd0, 8'd0,  8'd0,  0, 8'h80};
        vt[7] = '{1, 1, 3'd4, 8'hF0,  8'h3C,  3'd3, 8'hF0, 8'd4,  1, 8'h0F};
        lone[0] = '{0, 1, 3'd0, 8'd0, 8'd0, 3'd2, 8'h81, 8'd1,  1, 8'h02};
        lone[1] = '{0, 1, 3'd0, 8'd0, 8'd0, 3'd3, 8'h80, 8'd7,  1, 8'h01};
        lone[2] = '{0, 1, 3'd0, 8'd0, 8'd0, 3'd4, 8'hF0, 8'h3C, 1, 8'h30};
        lone[3] = '{0, 1, 3'd0, 8'd0, 8'd0, 3'd5, 8'hF0, 8'h0F, 1, 8'hFF};

        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2; req0_op = 3'd0;
        req1_valid = 1'b1; req1_a = 8'd3; req1_b = 8'd4; req1_op = 3'd0;
        #12;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_alu", {alu_a, alu_b, 5'd0, alu_op}, 32'd0);
        chk("rst_rsp", {rsp_data, 7'd0, rsp_src}, 32'd0);
        chk("rst_cnt", {done_cnt1, done_cnt0}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));
        chk("vec_cnt0", done_cnt0, 4);
        chk("vec_cnt1", done_cnt1, 4);

        // Continuous contention, consumer always ready
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'd5;   req0_b = 8'd7;
        req1_valid = 1'b1; req1_op = 3'd7; req1_a = 8'h3C; req1_b = 8'h3C;
        rsp_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
            if (rsp_valid && rsp_ready) begin
                c_data[got] = rsp_data; c_src[got] = rsp_src; c_cyc[got] = cyc; got++;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_count", got, 3);
        if (got == 3) begin
            chk("cont_d0", {c_src[0], c_data[0]}, {1'b0, 8'hFE});
            chk("cont_d1", {c_src[1], c_data[1]}, {1'b1, 8'h01});
            chk("cont_d2", {c_src[2], c_data[2]}, {1'b0, 8'hFE});
            chk("cont_gap01", c_cyc[1] - c_cyc[0], 3);
            chk("cont_gap12", c_cyc[2] - c_cyc[1], 3);
        end
        wait_idle();

        // Backpressure: RESP held 10 cycles, requests stalled
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'd1; req0_b = 8'd2;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd6; req1_a = 8'h0F; req1_b = 8'hFF;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_data", rsp_data, 8'd3);
            chk("bp_src", rsp_src, 1'b0);
            chk("bp_readys", {req0_ready, req1_ready}, 2'b00);
            chk("bp_busy", busy, 1'b1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_idle", busy, 1'b0);
        chk("bp_next_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        wait_idle();

        c1 = done_cnt1;
        for (int i = 0; i < 4; i++) run_vec(lone[i], $sformatf("lone%0d", i));
        chk("lone_cnt1", done_cnt1, CW'(c1 + 4));

        // Async reset while the op is in EXEC
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h11; req0_b = 8'h22;
        tick();
        req0_valid = 1'b0;
        chk("ar_busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 1'b0);
        chk("ar_rsp_valid", rsp_valid, 1'b0);
        chk("ar_alu", {alu_a, alu_b, 5'd0, alu_op}, 32'd0);
        chk("ar_rsp", {rsp_data, 7'd0, rsp_src}, 32'd0);
        chk("ar_cnt", {done_cnt1, done_cnt0}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_no_rsp", rsp_valid, 1'b0);
        end
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("ar_first_gnt", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        // Counter wrap on a CNTW=4 build: 16 ops on req0
        c0 = done_cnt0; c1 = done_cnt1;
        req0_op = 3'd4; req0_a = 8'hFF; req0_b = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            req0_valid = 1'b1;
            tick();
            req0_valid = 1'b0;
            wait_idle();
            if (i == 14) chk("wrap_pre", done_cnt0, CW'(c0 + 15));
        end
        chk("wrap_cnt0", done_cnt0, c0);
        chk("wrap_cnt1", done_cnt1, c1);

        // Random traffic against a transaction-level model
        rst_n = 1'b0; #2 rst_n = 1'b1;
        m_busy = 0; m_age = 0; m_last = 1'b1; m_cnt[0] = 0; m_cnt[1] = 0; m_src = 0; m_res = 0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        tick();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            #1;
            e_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
            e_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            vis  = m_busy && m_age >= 2;
            chk("rnd_ready0", req0_ready, e_r0);
            chk("rnd_ready1", req1_ready, e_r1);
            chk("rnd_busy", busy, m_busy);
            chk("rnd_rsp_valid", rsp_valid, vis);
            if (vis) chk("rnd_rsp", {rsp_src, rsp_data}, {m_src, m_res});
            chk("rnd_cnt", {done_cnt1, done_cnt0}, {CW'(m_cnt[1]), CW'(m_cnt[0])});
            if (vis && rsp_ready) begin
                m_cnt[m_src] = m_cnt[m_src] + 1;
                m_busy = 0;
            end else if (m_busy) begin
                m_age++;
            end else if (e_r0 || e_r1) begin
                m_busy = 1; m_age = 1; m_src = e_r1; m_last = e_r1;
                m_res = e_r1 ? alu_f(req1_op, req1_a, req1_b) : alu_f(req0_op, req0_a, req0_b);
            end
            @(posedge clk); #1;
            if (e_r0 || !req0_valid) begin
                req0_valid = ($urandom_range(2) != 0);
                req0_op = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
            end else if ($urandom_range(7) == 0) begin
                req0_valid = 1'b0;
            end
            if (e_r1 || !req1_valid) begin
                req1_valid = ($urandom_range(2) != 0);
                req1_op = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
            end else if ($urandom_range(7) == 0) begin
                req1_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
